decodificador_display_monitor: RTL and testbench

- Observes a multiplexed 7-segment bus: segments g..a, common-cathode, 1 = lit; anodes active-low, one per digit.
- Recovers the BCD value shown on each digit and flags patterns that are not legal glyphs.
- Used as on-chip self-check and loopback monitor for the counter/display path, with the display bus fed back into its inputs.
- Also usable as a scoreboard front-end in system benches.

---
 rtl/decodificador_display_monitor_if.sv | 25 ++
 rtl/decodificador_display_monitor.sv | 171 +++++++++++++++++
 tb/tb_decodificador_display_monitor.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/decodificador_display_monitor_if.sv
// Display bus seen by the monitor: the observed segment/anode lines plus the decoded results.
interface decodificador_display_monitor_if #(
    parameter int unsigned NUM_DIGITOS = 3
);
    logic [6:0]               segmentos_in;
    logic [NUM_DIGITOS-1:0]   anodos_in;
    logic [4*NUM_DIGITOS-1:0] digitos_out;
    logic [NUM_DIGITOS-1:0]   validos_out;
    logic [NUM_DIGITOS-1:0]   error_out;
    logic                     nuevo_dato_out;
    logic [2:0]               indice_out;
    logic                     conflicto_out;

    // Source side: drives the display lines, observes the decoded results.
    modport master (
        output segmentos_in, anodos_in,
        input  digitos_out, validos_out, error_out, nuevo_dato_out, indice_out, conflicto_out
    );

    // Monitor side.
    modport slave (
        input  segmentos_in, anodos_in,
        output digitos_out, validos_out, error_out, nuevo_dato_out, indice_out, conflicto_out
    );
endinterface

// File: rtl/decodificador_display_monitor.sv
// Multiplexed 7-segment bus monitor: recovers each digit's BCD value and flags illegal glyphs.
// Optional macro DECODE_HEX_EN: also accepts the A..F glyphs as legal values 10..15.
module decodificador_display_monitor #(
    parameter int unsigned NUM_DIGITOS    = 3,
    parameter int unsigned ESTABLE_CICLOS = 4,
    parameter int unsigned TIMEOUT_CICLOS = 65535
) (
    input  logic                          reloj,
    input  logic                          reset_n,
    decodificador_display_monitor_if.slave bus
);
    localparam int unsigned PALABRA_W = 7 + NUM_DIGITOS;
    localparam int unsigned ESTABLE_W = 8;
    localparam int unsigned TIMEOUT_W = $clog2(TIMEOUT_CICLOS + 1);
    localparam int unsigned DIGITOS_W = 4 * NUM_DIGITOS;

    // Glyph table lookup: returns {legal, value}; illegal patterns give value F.
    function automatic logic [4:0] decodificar(input logic [6:0] seg);
        case (seg)
            7'b0111111: decodificar = {1'b1, 4'd0};
            7'b0000110: decodificar = {1'b1, 4'd1};
            7'b1011011: decodificar = {1'b1, 4'd2};
            7'b1001111: decodificar = {1'b1, 4'd3};
            7'b1100110: decodificar = {1'b1, 4'd4};
            7'b1101101: decodificar = {1'b1, 4'd5};
            7'b1111101: decodificar = {1'b1, 4'd6};
            7'b0000111: decodificar = {1'b1, 4'd7};
            7'b1111111: decodificar = {1'b1, 4'd8};
            7'b1101111: decodificar = {1'b1, 4'd9};
`ifdef DECODE_HEX_EN
            7'b1110111: decodificar = {1'b1, 4'hA};
            7'b1111100: decodificar = {1'b1, 4'hB};
            7'b0111001: decodificar = {1'b1, 4'hC};
            7'b1011110: decodificar = {1'b1, 4'hD};
            7'b1111001: decodificar = {1'b1, 4'hE};
            7'b1110001: decodificar = {1'b1, 4'hF};
`endif
            default:    decodificar = {1'b0, 4'hF};
        endcase
    endfunction

    logic [PALABRA_W-1:0] sinc1_q, sinc2_q, previo_q;
    logic [2:0]           lleno_q;
    logic [ESTABLE_W-1:0] estable_q, estable_d;
    logic                 listo, iguales, paso;
    logic                 pend_q;
    logic [PALABRA_W-1:0] pend_palabra_q;

    // Synchronizer, previous-word register, stability counter and capture stage.
    // lleno_q tracks which pipeline stages hold real post-reset samples so the
    // reset contents are never mistaken for a stable pattern.
    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            sinc1_q        <= '0;
            sinc2_q        <= '0;
            previo_q       <= '0;
            lleno_q        <= '0;
            estable_q      <= '0;
            pend_q         <= 1'b0;
            pend_palabra_q <= '0;
        end else begin
            sinc1_q   <= {bus.segmentos_in, bus.anodos_in};
            sinc2_q   <= sinc1_q;
            previo_q  <= sinc2_q;
            lleno_q   <= {lleno_q[1:0], 1'b1};
            estable_q <= estable_d;
            pend_q    <= paso;
            if (paso) begin
                pend_palabra_q <= previo_q;
            end
        end
    end

    // Stability counting: capture fires only on the step into ESTABLE_CICLOS.
    always_comb begin
        listo     = lleno_q[2];
        iguales   = (sinc2_q == previo_q);
        paso      = listo && iguales && (estable_q == ESTABLE_W'(ESTABLE_CICLOS - 1));
        estable_d = estable_q;
        if (!listo || !iguales) begin
            estable_d = '0;
        end else if (estable_q != ESTABLE_W'(ESTABLE_CICLOS)) begin
            estable_d = estable_q + ESTABLE_W'(1);
        end
    end

    logic [NUM_DIGITOS-1:0] anodos_p;
    logic [3:0]             n_bajos;
    logic [2:0]             indice_c;
    logic [4:0]             glifo;
    logic                   escribe;

    // Classify the captured word by how many anodes are low.
    always_comb begin
        anodos_p = pend_palabra_q[NUM_DIGITOS-1:0];
        glifo    = decodificar(pend_palabra_q[PALABRA_W-1 -: 7]);
        n_bajos  = '0;
        indice_c = '0;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (!anodos_p[i]) begin
                n_bajos  = n_bajos + 4'd1;
                indice_c = 3'(i);
            end
        end
        escribe = pend_q && (n_bajos == 4'd1);
    end

    logic [DIGITOS_W-1:0]                   digitos_q, digitos_d;
    logic [NUM_DIGITOS-1:0]                 validos_q, validos_d;
    logic [NUM_DIGITOS-1:0]                 error_q, error_d;
    logic                                   nuevo_q, nuevo_d;
    logic [2:0]                             indice_q, indice_d;
    logic                                   conflicto_q, conflicto_d;
    logic [NUM_DIGITOS-1:0][TIMEOUT_W-1:0] tout_q, tout_d;

    // Digit register updates and per-digit freshness timers; a capture beats a timeout.
    always_comb begin
        digitos_d   = digitos_q;
        validos_d   = validos_q;
        error_d     = error_q;
        indice_d    = indice_q;
        tout_d      = tout_q;
        nuevo_d     = escribe;
        conflicto_d = pend_q && (n_bajos > 4'd1);
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (escribe && (indice_c == 3'(i))) begin
                tout_d[i]            = '0;
                digitos_d[4*i +: 4]  = glifo[3:0];
                validos_d[i]         = glifo[4];
                error_d[i]           = ~glifo[4];
            end else if (tout_q[i] != TIMEOUT_W'(TIMEOUT_CICLOS)) begin
                tout_d[i] = tout_q[i] + TIMEOUT_W'(1);
                if (tout_q[i] == TIMEOUT_W'(TIMEOUT_CICLOS - 1)) begin
                    validos_d[i] = 1'b0;
                end
            end
        end
        if (escribe) begin
            indice_d = indice_c;
        end
    end

    // Output and timer registers.
    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            digitos_q   <= '1;
            validos_q   <= '0;
            error_q     <= '0;
            nuevo_q     <= 1'b0;
            indice_q    <= '0;
            conflicto_q <= 1'b0;
            tout_q      <= '0;
        end else begin
            digitos_q   <= digitos_d;
            validos_q   <= validos_d;
            error_q     <= error_d;
            nuevo_q     <= nuevo_d;
            indice_q    <= indice_d;
            conflicto_q <= conflicto_d;
            tout_q      <= tout_d;
        end
    end

    assign bus.digitos_out    = digitos_q;
    assign bus.validos_out    = validos_q;
    assign bus.error_out      = error_q;
    assign bus.nuevo_dato_out = nuevo_q;
    assign bus.indice_out     = indice_q;
    assign bus.conflicto_out  = conflicto_q;

endmodule

// File: tb/tb_decodificador_display_monitor.sv
// Bench for decodificador_display_monitor: vector table, scoreboard queue and reference model.
module tb_decodificador_display_monitor;
    localparam int N    = 3;
    localparam int EST  = 4;
    localparam int TOUT = 20;
    localparam int LAT  = EST + 3;
`ifdef DECODE_HEX_EN
    localparam bit HEX = 1'b1;
`else
    localparam bit HEX = 1'b0;
`endif

    logic reloj;
    logic reset_n;

    decodificador_display_monitor_if #(.NUM_DIGITOS(N)) bus ();

    decodificador_display_monitor #(
        .NUM_DIGITOS(N), .ESTABLE_CICLOS(EST), .TIMEOUT_CICLOS(TOUT)
    ) dut (
        .reloj(reloj), .reset_n(reset_n), .bus(bus)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    typedef struct {
        logic [6:0] seg;
        logic [2:0] an;
        int         kind;   // 1 = digit write, 2 = conflict
        int         idx;
        logic [3:0] val;
        bit         legal;
    } vec_t;

    typedef struct {
        int         cyc;
        int         kind;
        int         idx;
        logic [3:0] nib;
        bit         legal;
    } exp_t;

    vec_t tabla[18];
    exp_t cola[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [11:0] m_dig;
    logic [2:0]  m_err, m_legal, m_val;
    int          m_cap[N];

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, act, req);
        end
    endtask

    task automatic modelo_reset();
        m_dig   = 12'hFFF;
        m_err   = '0;
        m_legal = '0;
        for (int i = 0; i < N; i++) m_cap[i] = -1000;
        cola.delete();
    endtask

    task automatic drive(input logic [6:0] s, input logic [2:0] a);
        @(negedge reloj);
        bus.segmentos_in = s;
        bus.anodos_in    = a;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge reloj);
    endtask

    // First sample is the next rising edge; the result registers LAT edges later.
    task automatic push(input int kind, input int idx, input logic [3:0] val, input bit legal);
        exp_t e;
        e.cyc = cyc + 1 + LAT;
        e.kind = kind;
        e.idx = idx;
        e.nib = val;
        e.legal = legal;
        cola.push_back(e);
    endtask

    // Monitor: pops expected events on their due cycle and checks outputs against the model.
    initial begin
        exp_t e;
        forever begin
            @(posedge reloj);
            cyc++;
            #1;
            if (cola.size() > 0 && cola[0].cyc == cyc) begin
                e = cola.pop_front();
                if (e.kind == 1) begin
                    check("pulso_dato", bus.nuevo_dato_out === 1'b1 && bus.conflicto_out === 1'b0,
                          {bus.nuevo_dato_out, bus.conflicto_out}, 2'b10);
                    check("indice", bus.indice_out === 3'(e.idx), bus.indice_out, e.idx);
                    m_dig[4*e.idx +: 4] = e.legal ? e.nib : 4'hF;
                    m_legal[e.idx]      = e.legal;
                    m_err[e.idx]        = !e.legal;
                    m_cap[e.idx]        = cyc;
                end else begin
                    check("pulso_conflicto", bus.conflicto_out === 1'b1 && bus.nuevo_dato_out === 1'b0,
                          {bus.nuevo_dato_out, bus.conflicto_out}, 2'b01);
                end
            end else begin
                check("sin_pulso", bus.nuevo_dato_out === 1'b0 && bus.conflicto_out === 1'b0,
                      {bus.nuevo_dato_out, bus.conflicto_out}, 2'b00);
            end
            for (int i = 0; i < N; i++) m_val[i] = m_legal[i] && ((cyc - m_cap[i]) < TOUT);
            check("digitos", bus.digitos_out === m_dig, bus.digitos_out, m_dig);
            check("validos", bus.validos_out === m_val, bus.validos_out, m_val);
            check("error",   bus.error_out   === m_err, bus.error_out, m_err);
        end
    end

    initial begin
        int c;
        tabla[0]  = '{7'b1011011, 3'b110, 1, 0, 4'd2, 1'b1};
        tabla[1]  = '{7'b0000110, 3'b101, 1, 1, 4'd1, 1'b1};
        tabla[2]  = '{7'b1010101, 3'b011, 1, 2, 4'hF, 1'b0};
        tabla[3]  = '{7'b1111111, 3'b100, 2, 0, 4'h0, 1'b0};
        tabla[4]  = '{7'b1101101, 3'b110, 1, 0, 4'd5, 1'b1};
        tabla[5]  = '{7'b1111101, 3'b101, 1, 1, 4'd6, 1'b1};
        tabla[6]  = '{7'b0000111, 3'b011, 1, 2, 4'd7, 1'b1};
        tabla[7]  = '{7'b1111111, 3'b110, 1, 0, 4'd8, 1'b1};
        tabla[8]  = '{7'b1101111, 3'b101, 1, 1, 4'd9, 1'b1};
        tabla[9]  = '{7'b0111111, 3'b011, 1, 2, 4'd0, 1'b1};
        tabla[10] = '{7'b1001111, 3'b110, 1, 0, 4'd3, 1'b1};
        tabla[11] = '{7'b1100110, 3'b101, 1, 1, 4'd4, 1'b1};
        tabla[12] = '{7'b1110111, 3'b110, 1, 0, 4'hA, HEX};
        tabla[13] = '{7'b1111100, 3'b011, 1, 2, 4'hB, HEX};
        tabla[14] = '{7'b0111001, 3'b101, 1, 1, 4'hC, HEX};
        tabla[15] = '{7'b1011110, 3'b110, 1, 0, 4'hD, HEX};
        tabla[16] = '{7'b1110001, 3'b011, 1, 2, 4'hF, HEX};
        tabla[17] = '{7'b0000110, 3'b000, 2, 0, 4'h0, 1'b0};

        reset_n          = 1'b0;
        bus.segmentos_in = 7'b0;
        bus.anodos_in    = 3'b111;
        modelo_reset();
        hold(3);
        check("reset_indice", bus.indice_out === 3'd0, bus.indice_out, 0);
        check("reset_digitos", bus.digitos_out === 12'hFFF, bus.digitos_out, 12'hFFF);
        reset_n = 1'b1;
        hold(12);

        // Table: each vector held long enough to capture, followed by a blanking word.
        for (int v = 0; v < 18; v++) begin
            drive(tabla[v].seg, tabla[v].an);
            push(tabla[v].kind, tabla[v].idx, tabla[v].val, tabla[v].legal);
            hold(10);
            drive(7'b0, 3'b111);
            hold(10);
        end

        // Pattern toggling every 2 cycles never becomes stable.
        for (int t = 0; t < 10; t++) begin
            drive(t[0] ? 7'b1001111 : 7'b0000110, 3'b101);
            hold(1);
        end
        drive(7'b0, 3'b111);
        hold(12);

        // Freshness timeout: 9 on digit 0, then blanking.
        drive(7'b1101111, 3'b110);
        c = cyc + 1 + LAT;
        push(1, 0, 4'd9, 1'b1);
        hold(9);
        drive(7'b0, 3'b111);
        while (cyc < c + TOUT - 1) @(negedge reloj);
        check("tout_antes", bus.validos_out[0] === 1'b1, bus.validos_out[0], 1);
        @(negedge reloj);
        check("tout_cae", bus.validos_out[0] === 1'b0, bus.validos_out[0], 0);
        check("tout_digito", bus.digitos_out[3:0] === 4'd9, bus.digitos_out[3:0], 9);
        hold(5);

        // Reset two cycles into a stable pattern; capture restarts after release.
        drive(7'b0000111, 3'b101);
        hold(2);
        reset_n = 1'b0;
        modelo_reset();
        hold(2);
        check("reset_nuevo", bus.nuevo_dato_out === 1'b0, bus.nuevo_dato_out, 0);
        reset_n = 1'b1;
        push(1, 1, 4'd7, 1'b1);
        hold(14);
        check("post_reset_digito", bus.digitos_out[7:4] === 4'd7, bus.digitos_out[7:4], 7);

        drive(7'b0, 3'b111);
        hold(20);
        check("cola_vacia", cola.size() == 0, cola.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
